// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment reader: active-low segment patterns
// (bit 0 = a ... bit 6 = g), the blank pattern and the reader FSM state encoding.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] reader_state_t;
  localparam reader_state_t ST_IDLE    = 2'd0;
  localparam reader_state_t ST_SETTLE  = 2'd1;
  localparam reader_state_t ST_CAPTURE = 2'd2;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Combinational segment-pattern lookup. Hex letters A..F decode only when
// SEG_READER_HEX_EN is defined; otherwise they are reported as invalid.
module seg_pattern_to_bcd
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    value   = 4'd0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (seg)
      SEG_0: value = 4'd0;
      SEG_1: value = 4'd1;
      SEG_2: value = 4'd2;
      SEG_3: value = 4'd3;
      SEG_4: value = 4'd4;
      SEG_5: value = 4'd5;
      SEG_6: value = 4'd6;
      SEG_7: value = 4'd7;
      SEG_8: value = 4'd8;
      SEG_9: value = 4'd9;
`ifdef SEG_READER_HEX_EN
      SEG_A: value = 4'd10;
      SEG_B: value = 4'd11;
      SEG_C: value = 4'd12;
      SEG_D: value = 4'd13;
      SEG_E: value = 4'd14;
      SEG_F: value = 4'd15;
`endif
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers digit values from a multiplexed active-low seven-segment drive.
// Optional hex decoding is enabled with the SEG_READER_HEX_EN macro.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_valid,
  output logic                    err,
  output logic [1:0]              state
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] snap_an;
  logic [6:0]            snap_seg;
  logic [7:0]            cnt;
  logic                  done;
  logic [NUM_DIGITS-1:0] mask;
  logic                  an_ok;
  logic                  same_in;
  logic [2:0]            idx;
  logic [3:0]            dec_value;
  logic                  dec_blank;
  logic                  dec_invalid;

  assign an_ok   = $onehot(~an);
  assign same_in = (an == snap_an) && (seg == snap_seg);

  // Digit index of the single low anode in the captured snapshot.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!snap_an[i]) idx = i[2:0];
    end
  end

  seg_pattern_to_bcd u_decode (
    .seg     (snap_seg),
    .value   (dec_value),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      snap_an     <= '1;
      snap_seg    <= SEG_BLANK;
      done        <= 1'b0;
      mask        <= '0;
      digits      <= '0;
      digit_blank <= '1;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (&mask) begin
        frame_valid <= 1'b1;
        mask        <= '0;
      end else begin
        frame_valid <= 1'b0;
      end

      // A capture error later in this block overrides the clear.
      if (err_clr) err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (an_ok) begin
            state    <= ST_SETTLE;
            snap_an  <= an;
            snap_seg <= seg;
            cnt      <= 8'd0;
            done     <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!an_ok) begin
            state <= ST_IDLE;
          end else if (!same_in) begin
            snap_an  <= an;
            snap_seg <= seg;
            cnt      <= 8'd0;
            if (an != snap_an) done <= 1'b0;
          end else if (!done && cnt == CNT_LAST) begin
            state <= ST_CAPTURE;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_CAPTURE: begin
          if (!an_ok) begin
            state <= ST_IDLE;
          end else begin
            state               <= ST_SETTLE;
            digits[4*idx +: 4]  <= dec_value;
            digit_blank[idx]    <= dec_blank;
            mask[idx]           <= 1'b1;
            if (dec_invalid) err <= 1'b1;
            // Inputs are also compared this cycle so a change is never missed.
            if (!same_in) begin
              snap_an  <= an;
              snap_seg <= seg;
              cnt      <= 8'd0;
              done     <= (an == snap_an);
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: per-cycle comparison against a
// behavioural model plus directed literal checks.
module tb_seven_seg_reader;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic        err_clr = 1'b0;
  logic [31:0] digits;
  logic [7:0]  digit_blank;
  logic        frame_valid;
  logic        err;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  logic sim_done = 1'b0;

  seven_seg_reader #(.NUM_DIGITS(8), .SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_blank (digit_blank),
    .frame_valid (frame_valid),
    .err         (err),
    .state       (state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [6:0]  pat_tab [16];
  int          tab_n;
  logic [31:0] m_digits = '0;
  logic [7:0]  m_blank = 8'hFF;
  logic        m_err = 1'b0;
  logic        m_fv = 1'b0;
  logic [7:0]  m_mask = '0;
  logic [7:0]  prev_a = 8'hFF;
  logic [6:0]  prev_s = 7'h7F;
  logic        prev_ok = 1'b0;
  logic        captured = 1'b0;
  logic        pending = 1'b0;
  logic [7:0]  pend_a = 8'hFF;
  logic [6:0]  pend_s = 7'h7F;
  int          run = 0;

  function automatic void lookup(input logic [6:0] s, output logic [3:0] v,
                                 output logic bl, output logic bad);
    v = 4'd0; bl = 1'b0; bad = 1'b1;
    if (s == 7'b1111111) begin
      bl = 1'b1; bad = 1'b0;
    end else begin
      for (int k = 0; k < tab_n; k++)
        if (pat_tab[k] == s) begin v = k[3:0]; bad = 1'b0; end
    end
  endfunction

  task automatic model_step();
    logic [3:0] v;
    logic bl, bad;
    int di;
    if (reset) begin
      m_digits = '0; m_blank = 8'hFF; m_err = 1'b0; m_fv = 1'b0; m_mask = '0;
      prev_ok = 1'b0; captured = 1'b0; pending = 1'b0; run = 0;
      return;
    end
    if (m_mask == 8'hFF) begin m_fv = 1'b1; m_mask = '0; end
    else m_fv = 1'b0;
    bad = 1'b0;
    if (pending && $countones(~an) == 1) begin
      lookup(pend_s, v, bl, bad);
      di = 0;
      for (int k = 0; k < 8; k++) if (!pend_a[k]) di = k;
      m_digits[4*di +: 4] = v;
      m_blank[di] = bl;
      m_mask[di] = 1'b1;
      captured = 1'b1;
    end
    pending = 1'b0;
    if (bad) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if ($countones(~an) != 1) begin
      prev_ok = 1'b0; captured = 1'b0;
    end else if (!prev_ok || an != prev_a || seg != prev_s) begin
      if (!prev_ok || an != prev_a) captured = 1'b0;
      prev_ok = 1'b1; prev_a = an; prev_s = seg; run = 0;
    end else begin
      if (run < 1000) run++;
      // S+1 consecutive identical samples, capture committed on the next edge
      if (run == S && !captured) begin
        pending = 1'b1; pend_a = an; pend_s = seg;
      end
    end
  endtask

  initial begin
    pat_tab[0] = 7'b1000000; pat_tab[1] = 7'b1111001; pat_tab[2] = 7'b0100100;
    pat_tab[3] = 7'b0110000; pat_tab[4] = 7'b0011001; pat_tab[5] = 7'b0010010;
    pat_tab[6] = 7'b0000010; pat_tab[7] = 7'b1111000; pat_tab[8] = 7'b0000000;
    pat_tab[9] = 7'b0011000; pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
    pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001; pat_tab[14] = 7'b0000110;
    pat_tab[15] = 7'b0001110;
`ifdef SEG_READER_HEX_EN
    tab_n = 16;
`else
    tab_n = 10;
`endif
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!sim_done) begin
        if (frame_valid === 1'b1) fv_cnt++;
        check("cyc_digits", digits, m_digits);
        check("cyc_blank", {24'd0, digit_blank}, {24'd0, m_blank});
        check("cyc_frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
        check("cyc_err", {31'd0, err}, {31'd0, m_err});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    an = ~(8'd1 << d);
    seg = s;
    tick(n);
  endtask

  int n;
  int fv_before;
  logic [31:0] exp_hex_digits;
  logic        exp_hex_err;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_digits", digits, 32'h0);
    check("rst_blank", {24'd0, digit_blank}, 32'hFF);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'h0);
    check("rst_err", {31'd0, err}, 32'h0);
    check("rst_state", {30'd0, state}, 32'h0);

    // Eight digits showing 0..7, each held 40 cycles
    fv_before = fv_cnt;
    for (int i = 0; i < 8; i++) show(i, pat_tab[i], 40);
    an = 8'hFF;
    tick(4);
    check("frame_digits", digits, 32'h76543210);
    check("frame_model_pin", m_digits, 32'h76543210);
    check("frame_blank", {24'd0, digit_blank}, 32'h0);
    check("frame_pulses", fv_cnt - fv_before, 1);
    check("frame_err", {31'd0, err}, 32'h0);

    // Glitch on digit 3 after 10 stable cycles, then measure latency
    show(3, pat_tab[9], 10);
    seg = pat_tab[8];
    tick(1);
    seg = pat_tab[9];
    n = 0;
    while (digits[15:12] != 4'd9 && n < 100) begin
      tick(1);
      n++;
    end
    // n counts edges from the write; the DUT sees the change on the first one
    check("glitch_latency", n - 1, S + 1);
    tick(20);
    check("glitch_digits", digits, 32'h76549210);

    // Invalid anode codes: no capture, FSM parked in IDLE
    an = 8'hFF; seg = pat_tab[5];
    tick(50);
    check("an_ff_state", {30'd0, state}, 32'h0);
    check("an_ff_digits", digits, 32'h76549210);
    an = 8'hFC;
    tick(50);
    check("an_fc_state", {30'd0, state}, 32'h0);
    check("an_fc_digits", digits, 32'h76549210);

    // Letter A on digit 2
`ifdef SEG_READER_HEX_EN
    exp_hex_digits = 32'h76549A10;
    exp_hex_err = 1'b0;
`else
    exp_hex_digits = 32'h76549010;
    exp_hex_err = 1'b1;
`endif
    show(1, pat_tab[1], 20);
    show(2, 7'b0001000, 40);
    check("hex_digits", digits, exp_hex_digits);
    check("hex_err", {31'd0, err}, {31'd0, exp_hex_err});
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("err_clr", {31'd0, err}, 32'h0);

    // err_clr held across a capture edge: a new error must still set err
    show(1, pat_tab[1], 20);
    an = 8'hFB; seg = 7'b0001000; err_clr = 1'b1;
    tick(S + 2);
    check("set_wins", {31'd0, err}, {31'd0, exp_hex_err});
    tick(1);
    check("clr_after_set", {31'd0, err}, 32'h0);
    err_clr = 1'b0;
    tick(5);

    // Blank digit 5, then reset in the middle of settling digit 6
    show(5, 7'b1111111, 40);
    check("blank_bit5", {31'd0, digit_blank[5]}, 32'h1);
    check("blank_field5", {28'd0, digits[23:20]}, 32'h0);
    show(6, pat_tab[4], 8);
    reset = 1'b1;
    tick(2);
    check("midrst_digits", digits, 32'h0);
    check("midrst_blank", {24'd0, digit_blank}, 32'hFF);
    check("midrst_frame_valid", {31'd0, frame_valid}, 32'h0);
    check("midrst_err", {31'd0, err}, 32'h0);
    check("midrst_state", {30'd0, state}, 32'h0);
    reset = 1'b0;
    an = 8'hFF;
    tick(3);
    show(0, pat_tab[5], 30);
    check("post_rst_digits", digits, 32'h00000005);
    check("post_rst_blank", {24'd0, digit_blank}, 32'hFE);

    @(negedge clk);
    sim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
